event_timer: RTL

//  Programmable countdown timer that emits a one-cycle event pulse on expiry.
//  It sits directly upstream of the sticky status flag: tick drives that flag's set input.

---
 rtl/event_timer.sv | 114 +++++++++++
 1 files changed

// File: rtl/event_timer.sv
// Programmable countdown timer with prescaler and one-cycle expiry pulse.
// Word-addressed register port: CTRL, PRESCALE, LOAD, COUNT.
module event_timer #(
   parameter int WIDTH = 32,
   parameter int PW    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [WIDTH-1:0] wd,
   output logic [WIDTH-1:0] rd,
   output logic             tick,
   output logic             busy
);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;
   logic [WIDTH-1:0] r_load;
   logic [PW-1:0]    r_pre;
   logic [PW-1:0]    w_pre_nxt;
   logic [PW-1:0]    r_prescale;
   logic             r_periodic;
   logic             w_periodic_nxt;
   logic             r_tick;
   logic             w_tick_nxt;
   logic             w_ctrl_wr;
   logic             w_strobe;

   assign w_ctrl_wr = we && (addr == 2'd0);
   assign w_strobe  = (r_pre >= r_prescale);

   // A CTRL write takes priority over any expiry on the same edge.
   always_comb begin
      w_state_nxt    = r_state;
      w_count_nxt    = r_count;
      w_pre_nxt      = r_pre;
      w_periodic_nxt = r_periodic;
      w_tick_nxt     = 1'b0;
      if (w_ctrl_wr) begin
         if (wd[0]) begin
            w_state_nxt    = S_RUN;
            w_count_nxt    = r_load;
            w_pre_nxt      = '0;
            w_periodic_nxt = wd[1];
         end else begin
            w_state_nxt = S_IDLE;
         end
      end else if (r_state == S_RUN) begin
         if (w_strobe) begin
            w_pre_nxt = '0;
            if (r_count != '0) begin
               w_count_nxt = r_count - WIDTH'(1);
            end else begin
               w_tick_nxt = 1'b1;
               if (r_periodic) begin
                  w_count_nxt = r_load;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end else begin
            w_pre_nxt = r_pre + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_pre      <= '0;
         r_periodic <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         r_pre      <= w_pre_nxt;
         r_periodic <= w_periodic_nxt;
         r_tick     <= w_tick_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_load     <= '0;
         r_prescale <= '0;
      end else if (we) begin
         if (addr == 2'd1) r_prescale <= wd[PW-1:0];
         if (addr == 2'd2) r_load     <= wd;
      end
   end

   assign tick = r_tick;
   assign busy = (r_state == S_RUN);

   always_comb begin
      rd = '0;
      case (addr)
         2'd0:    rd = {{(WIDTH-2){1'b0}}, r_periodic, busy};
         2'd1:    rd = {{(WIDTH-PW){1'b0}}, r_prescale};
         2'd2:    rd = r_load;
         default: rd = r_count;
      endcase
   end

endmodule
